// File: rtl/act_seq_ctrl.sv
// Activation sequencer: accumulates partial-sum tiles per row,
// then ReLU-registers and writes each row to the activation buffer.
module act_seq_ctrl #(
  parameter int TILE_W = 4,
  parameter int ROW_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic              acc_clr,
  output logic              acc_en,
  input  logic              buf_full,
  output logic              buf_wr_en,
  output logic [ROW_W-1:0]  buf_wr_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    RELU,
    WRITE,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TILE_W-1:0] tile_q;
  logic [TILE_W-1:0] tile_d;
  logic [TILE_W-1:0] tiles_m1_q;
  logic [TILE_W-1:0] tiles_m1_d;
  logic [ROW_W-1:0]  row_q;
  logic [ROW_W-1:0]  row_d;
  logic [ROW_W-1:0]  rows_m1_q;
  logic [ROW_W-1:0]  rows_m1_d;

  // State, counters and latched last-index configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tile_q     <= '0;
      tiles_m1_q <= '0;
      row_q      <= '0;
      rows_m1_q  <= '0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      tiles_m1_q <= tiles_m1_d;
      row_q      <= row_d;
      rows_m1_q  <= rows_m1_d;
    end
  end

  // Next-state and handshake/control outputs
  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    row_d       = row_q;
    tiles_m1_d  = tiles_m1_q;
    rows_m1_d   = rows_m1_q;
    psum_ready  = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    buf_wr_en   = 1'b0;
    buf_wr_addr = '0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        // rst_n gate keeps acc_clr low while reset is held
        if (start && rst_n) begin
          tiles_m1_d = (num_tiles == '0) ? '0
                     : num_tiles - 1'b1;
          rows_m1_d  = (num_rows == '0) ? '0
                     : num_rows - 1'b1;
          tile_d     = '0;
          row_d      = '0;
          acc_clr    = 1'b1;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        psum_ready = 1'b1;
        acc_en     = psum_valid;
        if (psum_valid) begin
          if (tile_q == tiles_m1_q) begin
            tile_d  = '0;
            state_d = RELU;
          end else begin
            tile_d = tile_q + 1'b1;
          end
        end
      end
      RELU: begin
        state_d = WRITE;
      end
      WRITE: begin
        buf_wr_en   = !buf_full;
        buf_wr_addr = row_q;
        if (!buf_full) begin
          if (row_q == rows_m1_q) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            acc_clr = 1'b1;
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_act_seq_ctrl.sv
// Bench for act_seq_ctrl: per-cycle output trace built from the
// job rules (tile handshakes, one ReLU cycle, stalled writes).
module tb_act_seq_ctrl;

  localparam int N = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_tiles = '0;
  logic [5:0] num_rows = '0;
  logic       psum_valid = 1'b0;
  logic       buf_full = 1'b0;
  logic       psum_ready;
  logic       acc_clr;
  logic       acc_en;
  logic       buf_wr_en;
  logic [5:0] buf_wr_addr;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_v [N];
  logic [11:0] obs_v [N];
  bit          vld [N];
  bit          ful [N];

  act_seq_ctrl #(
    .TILE_W(4),
    .ROW_W (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_tiles  (num_tiles),
    .num_rows   (num_rows),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .buf_full   (buf_full),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pk(
    bit r, bit c, bit e, bit w, bit b, bit d, int a
  );
    logic [5:0] a6;
    a6 = a[5:0];
    return {r, c, e, w, b, d, a6};
  endfunction

  function automatic logic [11:0] obs_now();
    return {psum_ready, acc_clr, acc_en,
            buf_wr_en, busy, done, buf_wr_addr};
  endfunction

  // Expected trace; returns index of the done cycle
  function automatic int build_exp(int tiles, int rows);
    int te;
    int re;
    int p;
    int k;
    te = (tiles == 0) ? 1 : tiles;
    re = (rows == 0) ? 1 : rows;
    for (int i = 0; i < N; i++) exp_v[i] = '0;
    exp_v[0] = pk(0, 1, 0, 0, 0, 0, 0);
    p = 1;
    for (int r = 0; r < re; r++) begin
      k = 0;
      while (k < te && p < N - 8) begin
        exp_v[p] = pk(1, 0, vld[p], 0, 1, 0, 0);
        if (vld[p]) k++;
        p++;
      end
      exp_v[p] = pk(0, 0, 0, 0, 1, 0, 0);
      p++;
      while (ful[p] && p < N - 8) begin
        exp_v[p] = pk(0, 0, 0, 0, 1, 0, r);
        p++;
      end
      exp_v[p] = pk(0, r != re - 1, 0, 1, 1, 0, r);
      p++;
    end
    exp_v[p] = pk(0, 0, 0, 0, 1, 1, 0);
    return p;
  endfunction

  task automatic fill(bit v, bit f);
    for (int i = 0; i < N; i++) begin
      vld[i] = v;
      ful[i] = f;
    end
  endtask

  task automatic drive(
    int tiles, int rows, bit hold, bit chg, int ncyc
  );
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        start     = 1'b1;
        num_tiles = tiles[3:0];
        num_rows  = rows[5:0];
      end else begin
        start = hold && (t < ncyc - 1);
        if (chg) begin
          num_tiles = 4'($urandom);
          num_rows  = 6'($urandom);
        end
      end
      psum_valid = vld[t];
      buf_full   = ful[t];
      @(negedge clk);
      obs_v[t] = obs_now();
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    psum_valid = 1'b0;
    buf_full   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    start      = 1'b1;
    psum_valid = 1'b1;
    #3;
    checks++;
    if (obs_now() !== 12'h000) begin
      errors++;
      $display("FAIL reset_async got %h exp 000", obs_now());
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs_now() !== 12'h000) begin
      errors++;
      $display("FAIL reset_held got %h exp 000", obs_now());
    end
    start      = 1'b0;
    psum_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_now() !== 12'h000) begin
      errors++;
      $display("FAIL reset_idle got %h exp 000", obs_now());
    end
  endtask

  task automatic test_basic();
    int len;
    fill(1, 0);
    len = build_exp(3, 2);
    drive(3, 2, 0, 0, len + 2);
    for (int t = 0; t < len + 2; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL basic cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_zero_cfg();
    int len;
    fill(1, 0);
    len = build_exp(0, 0);
    drive(0, 0, 0, 0, len + 2);
    for (int t = 0; t < len + 2; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL zero_cfg cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_valid_gaps();
    int len;
    fill(0, 0);
    vld[1] = 1;
    vld[4] = 1;
    len = build_exp(2, 1);
    drive(2, 1, 0, 0, len + 2);
    for (int t = 0; t < len + 2; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL valid_gaps cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_buf_stall();
    int len;
    fill(1, 0);
    for (int i = 4; i < 8; i++) ful[i] = 1;
    len = build_exp(2, 2);
    drive(2, 2, 0, 0, len + 2);
    for (int t = 0; t < len + 2; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL buf_stall cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_busy_start();
    int len;
    fill(1, 0);
    len = build_exp(3, 3);
    drive(3, 3, 1, 1, len + 2);
    for (int t = 0; t < len + 2; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL busy_start cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int len;
    fill(1, 0);
    len = build_exp(3, 2);
    drive(3, 2, 0, 0, 8);
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL mid_pre cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
    start      = 1'b1;
    psum_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_now() !== 12'h000) begin
      errors++;
      $display("FAIL mid_async got %h exp 000", obs_now());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_now() !== 12'h000) begin
        errors++;
        $display("FAIL mid_hold got %h exp 000", obs_now());
      end
    end
    start      = 1'b0;
    psum_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(3, 2, 0, 0, len + 2);
    for (int t = 0; t < len + 2; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL mid_rerun cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_max_rows();
    int len;
    fill(1, 0);
    len = build_exp(1, 63);
    drive(1, 63, 0, 0, len + 2);
    for (int t = 0; t < len + 2; t++) begin
      checks++;
      if (obs_v[t] !== exp_v[t]) begin
        errors++;
        $display("FAIL max_rows cyc %0d got %h exp %h",
                 t, obs_v[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    int tl;
    int rw;
    bit hold;
    bit chg;
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = ($urandom_range(0, 99) < 70);
        ful[i] = ($urandom_range(0, 99) < 30);
      end
      tl   = $urandom_range(0, 5);
      rw   = $urandom_range(0, 4);
      hold = 1'($urandom);
      chg  = 1'($urandom);
      len  = build_exp(tl, rw);
      drive(tl, rw, hold, chg, len + 2);
      for (int t = 0; t < len + 2; t++) begin
        checks++;
        if (obs_v[t] !== exp_v[t]) begin
          errors++;
          $display("FAIL random job %0d cyc %0d got %h exp %h",
                   j, t, obs_v[t], exp_v[t]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cfg();
    test_valid_gaps();
    test_buf_stall();
    test_busy_start();
    test_mid_reset();
    test_max_rows();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
